// File: rtl/ex_mem_elastic_reg_pkg.sv
// Shared constants and entry layout helpers for the EX->MEM elastic buffer.
// Entry packing, LSB first: wb_en, mem_r_en, mem_w_en, branch_taken, dest, val_rm, alu_res.
package ex_mem_elastic_reg_pkg;

   localparam int unsigned REGISTER_LEN    = 32;
   localparam int unsigned REG_ADDRESS_LEN = 4;

   localparam int unsigned EX_MEM_WB_EN_OFS    = 0;
   localparam int unsigned EX_MEM_MEM_R_EN_OFS = 1;
   localparam int unsigned EX_MEM_MEM_W_EN_OFS = 2;
   localparam int unsigned EX_MEM_BRANCH_OFS   = 3;
   localparam int unsigned EX_MEM_DEST_OFS     = 4;

   function automatic int unsigned ex_mem_entry_len(input int unsigned data_w,
                                                    input int unsigned addr_w);
      return 2 * data_w + addr_w + 4;
   endfunction

   function automatic int unsigned ex_mem_val_rm_ofs(input int unsigned addr_w);
      return EX_MEM_DEST_OFS + addr_w;
   endfunction

   function automatic int unsigned ex_mem_alu_res_ofs(input int unsigned data_w,
                                                      input int unsigned addr_w);
      return EX_MEM_DEST_OFS + addr_w + data_w;
   endfunction

   // Pointers keep at least one bit so DEPTH=1 still has a legal index signal.
   function automatic int unsigned ex_mem_ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ex_mem_elastic_reg_fifo_ctrl.sv
// Elastic FIFO control: occupancy count, circular pointers, handshake and flush.
module ex_mem_elastic_reg_fifo_ctrl
   import ex_mem_elastic_reg_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PtrW = ex_mem_ptr_w(DEPTH),
   localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            in_valid_i,
   input  logic            out_ready_i,
   output logic            in_ready_o,
   output logic            out_valid_o,
   output logic            push_o,
   output logic [PtrW-1:0] wr_ptr_o,
   output logic [PtrW-1:0] rd_ptr_o,
   output logic [CntW-1:0] count_o
);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push, pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (DEPTH == 1) ? '0 : p + PtrW'(1);
   endfunction

   // Handshake: DEPTH=1 lets a consumed head make room in the same cycle.
   always_comb begin
      out_valid_o = (count_q != '0);
      if (DEPTH == 1) begin
         in_ready_o = ~out_valid_o | out_ready_i;
      end else begin
         in_ready_o = (count_q < CntW'(DEPTH));
      end
      push = in_valid_i & in_ready_o & ~flush_i;
      pop  = out_valid_o & out_ready_i & ~flush_i;
   end

   // Next-state for pointers and count; flush wins over any transfer.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign push_o   = push;
   assign wr_ptr_o = wr_ptr_q;
   assign rd_ptr_o = rd_ptr_q;
   assign count_o  = count_q;

endmodule

// File: rtl/ex_mem_elastic_reg.sv
// EX->MEM elastic pipeline buffer with valid/ready handshake and branch flush.
// Optional forwarding lookup into buffered results when EX_MEM_FWD_EN is defined.
module ex_mem_elastic_reg
   import ex_mem_elastic_reg_pkg::*;
#(
   parameter int unsigned DATA_W = REGISTER_LEN,
   parameter int unsigned ADDR_W = REG_ADDRESS_LEN,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wb_en,
   input  logic              in_mem_r_en,
   input  logic              in_mem_w_en,
   input  logic              in_branch_taken,
   input  logic [DATA_W-1:0] in_alu_res,
   input  logic [DATA_W-1:0] in_val_rm,
   input  logic [ADDR_W-1:0] in_dest,
`ifdef EX_MEM_FWD_EN
   input  logic [ADDR_W-1:0] fwd_src1,
   input  logic [ADDR_W-1:0] fwd_src2,
   output logic              fwd_hit1,
   output logic              fwd_hit2,
   output logic [DATA_W-1:0] fwd_data1,
   output logic [DATA_W-1:0] fwd_data2,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_wb_en,
   output logic              out_mem_r_en,
   output logic              out_mem_w_en,
   output logic              out_branch_taken,
   output logic [DATA_W-1:0] out_alu_res,
   output logic [DATA_W-1:0] out_val_rm,
   output logic [ADDR_W-1:0] out_dest
);

   localparam int unsigned EntryW = ex_mem_entry_len(DATA_W, ADDR_W);
   localparam int unsigned RmOfs  = ex_mem_val_rm_ofs(ADDR_W);
   localparam int unsigned AluOfs = ex_mem_alu_res_ofs(DATA_W, ADDR_W);
   localparam int unsigned PtrW   = ex_mem_ptr_w(DEPTH);
   localparam int unsigned CntW   = $clog2(DEPTH + 1);

   logic              push;
   logic [PtrW-1:0]   wr_ptr, rd_ptr;
   logic [CntW-1:0]   count;
   logic [EntryW-1:0] mem_q [DEPTH];
   logic [EntryW-1:0] mem_d [DEPTH];
   logic [EntryW-1:0] in_entry, head;

   ex_mem_elastic_reg_fifo_ctrl #(
      .DEPTH (DEPTH)
   ) u_ctrl (
      .clk_i       (clk),
      .rst_ni      (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .out_ready_i (out_ready),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .push_o      (push),
      .wr_ptr_o    (wr_ptr),
      .rd_ptr_o    (rd_ptr),
      .count_o     (count)
   );

   assign in_entry = {in_alu_res, in_val_rm, in_dest,
                      in_branch_taken, in_mem_w_en, in_mem_r_en, in_wb_en};

   // Payload write on accepted push; flush and pop only touch validity.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
      if (push) mem_d[wr_ptr] = in_entry;
   end

   // Entry storage, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   // Head muxing; control bits masked so an empty buffer never issues writes.
   always_comb begin
      head             = mem_q[rd_ptr];
      out_wb_en        = out_valid & head[EX_MEM_WB_EN_OFS];
      out_mem_r_en     = out_valid & head[EX_MEM_MEM_R_EN_OFS];
      out_mem_w_en     = out_valid & head[EX_MEM_MEM_W_EN_OFS];
      out_branch_taken = out_valid & head[EX_MEM_BRANCH_OFS];
      out_dest         = head[EX_MEM_DEST_OFS +: ADDR_W];
      out_val_rm       = head[RmOfs +: DATA_W];
      out_alu_res      = head[AluOfs +: DATA_W];
   end

`ifdef EX_MEM_FWD_EN
   logic [PtrW-1:0]   fwd_idx;
   logic [EntryW-1:0] fwd_ent;

   // Scan oldest to youngest so the youngest eligible entry wins; loads are skipped.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = '0;
      fwd_data2 = '0;
      fwd_idx   = '0;
      fwd_ent   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = rd_ptr + PtrW'(k);
         fwd_ent = mem_q[fwd_idx];
         if ((k < int'(count)) && fwd_ent[EX_MEM_WB_EN_OFS] && !fwd_ent[EX_MEM_MEM_R_EN_OFS]) begin
            if (fwd_ent[EX_MEM_DEST_OFS +: ADDR_W] == fwd_src1) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = fwd_ent[AluOfs +: DATA_W];
            end
            if (fwd_ent[EX_MEM_DEST_OFS +: ADDR_W] == fwd_src2) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = fwd_ent[AluOfs +: DATA_W];
            end
         end
      end
   end
`else
   logic unused_count;
   assign unused_count = ^count;
`endif

endmodule
